mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 118 +++++++++++
 tb/tb_mem_copy_dma.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: alternates READ/WRITE cycles over a shared
// memory port. Rejects misaligned requests and supports abort.
module mem_copy_dma #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned ADDR_STRIDE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] src_ptr, dst_ptr, data_buf;
    logic [LEN_WIDTH-1:0]  count;
    logic                  err_q, err_d;
    logic                  load;
    logic                  misaligned;

    assign misaligned = (src_addr[2:0] != 3'd0) || (dst_addr[2:0] != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Abort wins over every READ/WRITE transition, including the last write.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = FINISH;
                    end else begin
                        load    = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ:   state_d = abort ? IDLE : WRITE;
            WRITE: begin
                if (abort)
                    state_d = IDLE;
                else if (count == LEN_WIDTH'(1))
                    state_d = FINISH;
                else
                    state_d = READ;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_buf <= '0;
        end else begin
            if (load) begin
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                count   <= len;
            end else if (state_q == WRITE) begin
                src_ptr <= src_ptr + DATA_WIDTH'(ADDR_STRIDE);
                dst_ptr <= dst_ptr + DATA_WIDTH'(ADDR_STRIDE);
                count   <= count - LEN_WIDTH'(1);
            end
            if (state_q == READ)
                data_buf <= mem_rdata;
        end
    end

    always_comb begin
        mem_addr = '0;
        case (state_q)
            READ:    mem_addr = src_ptr;
            WRITE:   mem_addr = dst_ptr;
            default: mem_addr = '0;
        endcase
    end

    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = data_buf;
    assign busy      = (state_q == READ) || (state_q == WRITE);
    assign done      = (state_q == FINISH);
    assign error     = err_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a small word-addressed memory model.
`timescale 1ns/1ps
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [7:0]  len;
    logic        abort;
    logic        busy, done, error, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    int          wr_cnt = 0;

    int checks = 0;
    int failures = 0;
    int ob_busy, ob_done, ob_done_at, ob_err, ob_err_at, ob_we;
    int wr_base;

    localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004, E = 32'hEEEE_0005, S = 32'h5E47_1E00;

    mem_copy_dma #(.DATA_WIDTH(32), .LEN_WIDTH(8), .ADDR_STRIDE(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .abort(abort), .busy(busy), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:3]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_we)
            mem[mem_addr[8:3]] <= mem_wdata;
        if (mem_we)
            wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (first cycle after start is sampled).
    task automatic start_req(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic observe(input int n);
        ob_busy = 0; ob_done = 0; ob_done_at = 0; ob_err = 0; ob_err_at = 0; ob_we = 0;
        for (int i = 1; i <= n; i++) begin
            if (busy) ob_busy++;
            if (mem_we) ob_we++;
            if (done) begin ob_done++; if (ob_done_at == 0) ob_done_at = i; end
            if (error) begin ob_err++; if (ob_err_at == 0) ob_err_at = i; end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        src_addr = '0; dst_addr = '0; len = '0;
        preload(6'd0, A); preload(6'd1, B); preload(6'd2, C); preload(6'd3, D);
        preload(6'd63, E); preload(6'd18, S); preload(6'd24, S); preload(6'd56, S);
        check("reset_outputs", {busy, done, error, mem_we}, 4'b0);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic copy of three words to 0x40
        start_req(32'h0, 32'h40, 8'd3);
        check("copy_first_read_addr", mem_addr, 32'h0);
        observe(8);
        check("copy_busy_cycles", ob_busy, 6);
        check("copy_done_cycle", ob_done_at, 7);
        check("copy_done_count", ob_done, 1);
        check("copy_writes", ob_we, 3);
        check("copy_w0", mem[8], A);
        check("copy_w1", mem[9], B);
        check("copy_w2", mem[10], C);

        // Misaligned request
        wr_base = wr_cnt;
        start_req(32'h4, 32'h40, 8'd2);
        observe(5);
        check("misal_err_cycle", ob_err_at, 1);
        check("misal_err_count", ob_err, 1);
        check("misal_busy", ob_busy, 0);
        check("misal_no_write", wr_cnt - wr_base, 0);

        // Empty request
        start_req(32'h0, 32'h40, 8'd0);
        observe(4);
        check("empty_done_cycle", ob_done_at, 1);
        check("empty_done_count", ob_done, 1);
        check("empty_busy", ob_busy, 0);
        check("empty_no_write", wr_cnt - wr_base, 0);

        // Abort in the second WRITE of a 4-word copy
        wr_base = wr_cnt;
        start_req(32'h0, 32'h80, 8'd4);
        repeat (3) @(negedge clk);
        check("abort_w2_we", mem_we, 1'b1);
        check("abort_w2_addr", mem_addr, 32'h88);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_next", {busy, done, mem_we}, 3'b0);
        observe(6);
        check("abort_no_done", ob_done, 0);
        check("abort_no_more_we", ob_we, 0);
        check("abort_write_count", wr_cnt - wr_base, 2);
        check("abort_w0", mem[16], A);
        check("abort_w1", mem[17], B);
        check("abort_w2_untouched", mem[18], S);

        // Address wrap on the source side
        start_req(32'hFFFF_FFF8, 32'h100, 8'd2);
        check("wrap_read0_addr", mem_addr, 32'hFFFF_FFF8);
        repeat (2) @(negedge clk);
        check("wrap_read1_addr", mem_addr, 32'h0);
        check("wrap_read1_we", mem_we, 1'b0);
        observe(4);
        check("wrap_done", ob_done, 1);
        check("wrap_w0", mem[32], E);
        check("wrap_w1", mem[33], A);

        // Asynchronous reset during READ
        wr_base = wr_cnt;
        start_req(32'h0, 32'hC0, 8'd3);
        check("rst_in_read_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {busy, done, error, mem_we}, 4'b0);
        check("rst_async_addr", mem_addr, 32'h0);
        check("rst_async_wdata", mem_wdata, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        observe(5);
        check("rst_no_busy_after", ob_busy, 0);
        check("rst_no_write", wr_cnt - wr_base, 0);
        check("rst_dst_untouched", mem[24], S);
        start_req(32'h0, 32'hC0, 8'd3);
        observe(8);
        check("rst_recopy_done_cycle", ob_done_at, 7);
        check("rst_recopy_w0", mem[24], A);
        check("rst_recopy_w2", mem[26], C);

        // Start while busy must be ignored
        wr_base = wr_cnt;
        start_req(32'h8, 32'hE0, 8'd2);
        start = 1'b1; src_addr = 32'h10; dst_addr = 32'h1C0; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        observe(7);
        check("busy_start_done", ob_done, 1);
        check("busy_start_writes", wr_cnt - wr_base, 2);
        check("busy_start_w0", mem[28], B);
        check("busy_start_w1", mem[29], C);
        check("busy_start_ignored", mem[56], S);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
